// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequential front end for the 16-bit combinational ALU.
// Accepts one instruction at a time, drives the ALU for a single EXEC cycle,
// writes the ALU result back into a 4-entry register file and presents it
// on a valid/ready result stream. A direct load port initialises registers.
//
//   state | meaning
//   IDLE  | waiting for an instruction; in_ready high
//   EXEC  | ALU driven with latched opcode and register operands
//   HOLD  | result presented on out_data until out_ready
module alu_issue_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [1:0]       in_rd,
  input  logic [1:0]       in_ra,
  input  logic [1:0]       in_rb,
  input  logic             in_cin,
  input  logic             ld_en,
  input  logic [1:0]       ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic [2:0]       alu_opc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_c,
  input  logic [WIDTH-1:0] alu_w,
  input  logic             alu_neg,
  input  logic             alu_zer,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             neg_f,
  output logic             zer_f
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] rf [4];
  logic [WIDTH-1:0] result;
  logic [2:0]       ir_op;
  logic [1:0]       ir_rd;
  logic [1:0]       ir_ra;
  logic [1:0]       ir_rb;
  logic             ir_cin;

  // Handshake outputs; in_ready is forced low while reset is asserted.
  assign in_ready  = (state == IDLE) & ~rst;
  assign out_valid = (state == HOLD);
  assign out_data  = result;

  // ALU drive: real operands only in EXEC, an inert pattern otherwise.
  always_comb begin
    alu_opc = 3'b111;
    alu_a   = '0;
    alu_b   = '0;
    alu_c   = 1'b0;
    if (state == EXEC) begin
      alu_opc = ir_op;
      alu_a   = rf[ir_ra];
      alu_b   = rf[ir_rb];
      alu_c   = ir_cin;
    end
  end

  // Sequencer, instruction register, register file, result and flags.
  // The load is written first so a same-index EXEC writeback overrides it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      for (int i = 0; i < 4; i++) rf[i] <= '0;
      result <= '0;
      neg_f  <= 1'b0;
      zer_f  <= 1'b0;
      ir_op  <= '0;
      ir_rd  <= '0;
      ir_ra  <= '0;
      ir_rb  <= '0;
      ir_cin <= 1'b0;
    end else begin
      if (ld_en) rf[ld_addr] <= ld_data;
      case (state)
        IDLE: begin
          if (in_valid) begin
            ir_op  <= in_op;
            ir_rd  <= in_rd;
            ir_ra  <= in_ra;
            ir_rb  <= in_rb;
            ir_cin <= in_cin;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rf[ir_rd] <= alu_w;
          result    <= alu_w;
          neg_f     <= alu_neg;
          zer_f     <= alu_zer;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU attached.
module tb_alu_issue_ctrl;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [1:0]       in_rd, in_ra, in_rb;
  logic             in_cin;
  logic             ld_en;
  logic [1:0]       ld_addr;
  logic [WIDTH-1:0] ld_data;
  logic [2:0]       alu_opc;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic             alu_c;
  logic [WIDTH-1:0] alu_w;
  logic             alu_neg, alu_zer;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             neg_f, zer_f;

  int n_pass = 0;
  int n_total = 0;

  alu_issue_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_ra(in_ra), .in_rb(in_rb), .in_cin(in_cin),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_opc(alu_opc), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .alu_w(alu_w), .alu_neg(alu_neg), .alu_zer(alu_zer),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .neg_f(neg_f), .zer_f(zer_f)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: only the opcodes used below matter.
  always_comb begin
    case (alu_opc)
      3'b000:  alu_w = -alu_a;
      3'b001:  alu_w = alu_a + 16'd1;
      3'b010:  alu_w = alu_a + alu_b + {15'd0, alu_c};
      3'b110:  alu_w = {alu_a[7:0], alu_b[7:0]};
      3'b111:  alu_w = '0;
      default: alu_w = alu_a;
    endcase
    alu_neg = alu_w[WIDTH-1];
    alu_zer = (alu_w == '0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] a, input logic [WIDTH-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    step();
    ld_en = 1'b0;
  endtask

  // Handshake one instruction; returns one step later, inside EXEC.
  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                       input logic [1:0] rb, input logic cin);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_ra = ra; in_rb = rb; in_cin = cin;
    step();
    in_valid = 1'b0;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_rd = '0; in_ra = '0; in_rb = '0;
    in_cin = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; out_ready = 1'b0;
    step();
    step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 16'h0000);
    chk("rst_flags", {neg_f, zer_f}, 2'b00);
    chk("idle_alu_opc", alu_opc, 3'b111);

    // Add with carry: 5 + 3 + 1
    load(2'd0, 16'h0005);
    load(2'd1, 16'h0003);
    issue(3'b010, 2'd2, 2'd0, 2'd1, 1'b1);
    chk("add_exec_opc", alu_opc, 3'b010);
    chk("add_exec_a", alu_a, 16'h0005);
    chk("add_exec_b", alu_b, 16'h0003);
    chk("add_exec_c", alu_c, 1'b1);
    chk("add_exec_ovalid", out_valid, 0);
    chk("add_exec_iready", in_ready, 0);
    step();
    chk("add_hold_ovalid", out_valid, 1);
    chk("add_hold_data", out_data, 16'h0009);
    chk("add_hold_flags", {neg_f, zer_f}, 2'b00);
    chk("add_hold_opc", alu_opc, 3'b111);
    chk("add_hold_a", alu_a, 16'h0000);
    release_out();
    chk("add_back_idle", in_ready, 1);

    // Negate r0 in place, then increment into r3
    issue(3'b000, 2'd0, 2'd0, 2'd0, 1'b0);
    chk("neg_exec_a", alu_a, 16'h0005);
    step();
    chk("neg_data", out_data, 16'hFFFB);
    chk("neg_flags", {neg_f, zer_f}, 2'b10);
    release_out();
    issue(3'b001, 2'd3, 2'd0, 2'd0, 1'b0);
    chk("inc_exec_a", alu_a, 16'hFFFB);
    step();
    chk("inc_data", out_data, 16'hFFFC);
    release_out();

    // Concat then zero; the zero op also reads back r2 and r1
    load(2'd0, 16'h12AB);
    load(2'd1, 16'h34CD);
    issue(3'b110, 2'd1, 2'd0, 2'd1, 1'b0);
    step();
    chk("cat_data", out_data, 16'hABCD);
    chk("cat_flags", {neg_f, zer_f}, 2'b10);
    release_out();
    issue(3'b111, 2'd2, 2'd2, 2'd1, 1'b0);
    chk("rf2_after_add", alu_a, 16'h0009);
    chk("rf1_after_cat", alu_b, 16'hABCD);
    step();
    chk("zero_data", out_data, 16'h0000);
    chk("zero_flags", {neg_f, zer_f}, 2'b01);

    // Backpressure: stay in HOLD with a changing instruction offered
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_op = 3'(i); in_rd = 2'(i); in_ra = 2'(i + 1); in_rb = 2'(i + 2); in_cin = i[0];
      step();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, 16'h0000);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_flags", {neg_f, zer_f}, 2'b01);
    end
    in_op = 3'b010; in_rd = 2'd2; in_ra = 2'd0; in_rb = 2'd1; in_cin = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_idle_ready", in_ready, 1);
    chk("bp_idle_ovalid", out_valid, 0);
    step();
    in_valid = 1'b0;
    chk("bp_next_opc", alu_opc, 3'b010);
    chk("bp_next_a", alu_a, 16'h12AB);
    chk("bp_next_b", alu_b, 16'hABCD);

    // Same-index load during EXEC loses to writeback
    ld_en = 1'b1; ld_addr = 2'd2; ld_data = 16'h7777;
    step();
    ld_en = 1'b0;
    chk("coll_data", out_data, 16'hBE78);
    chk("coll_flags", {neg_f, zer_f}, 2'b10);
    release_out();

    // Load to another index during EXEC takes effect after this cycle
    issue(3'b010, 2'd1, 2'd2, 2'd3, 1'b0);
    chk("coll_rf2_wb_wins", alu_a, 16'hBE78);
    chk("ld_exec_b_preedge", alu_b, 16'hFFFC);
    ld_en = 1'b1; ld_addr = 2'd3; ld_data = 16'h7777;
    step();
    ld_en = 1'b0;
    chk("ld_exec_data", out_data, 16'hBE74);
    release_out();

    // Reset in EXEC of an add targeting r1 (r1 = 3 beforehand)
    load(2'd1, 16'h0003);
    issue(3'b010, 2'd1, 2'd3, 2'd1, 1'b0);
    chk("ld_rf3_took", alu_a, 16'h7777);
    chk("rstx_exec_b", alu_b, 16'h0003);
    rst = 1'b1;
    ld_en = 1'b1; ld_addr = 2'd0; ld_data = 16'h1234;
    step();
    ld_en = 1'b0;
    chk("rstx_ovalid", out_valid, 0);
    chk("rstx_iready", in_ready, 0);
    chk("rstx_flags", {neg_f, zer_f}, 2'b00);
    chk("rstx_data", out_data, 16'h0000);
    rst = 1'b0;
    #1;
    chk("rstx_iready_after", in_ready, 1);
    step();
    chk("rstx_ovalid_later", out_valid, 0);
    issue(3'b111, 2'd2, 2'd1, 2'd0, 1'b0);
    chk("rstx_rf1_cleared", alu_a, 16'h0000);
    chk("rstx_rf0_ld_ignored", alu_b, 16'h0000);
    step();
    chk("final_flags", {neg_f, zer_f}, 2'b01);
    release_out();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
